// File: rtl/sd_block_server.sv
// sd_block_server
//   Host-side responder for the four-drive SD block request interface of the
//   floppy controller. Each granted request moves (blk_cnt+1) 512-byte blocks
//   between a byte-wide backing memory and the requester's sector buffer.
//   Backing memory layout: {drive[1:0], lba[10:0], byte[8:0]} (1 MB per drive).
//   Blocks whose number (lba + block index) exceeds 2047 lie outside the drive
//   window: reads return FILL, writes are dropped, and the memory is untouched.
//
// Ports
//   CLK, RESET_N     clock (rising edge), asynchronous active-low reset
//   sd_lba[d]        block address of drive d, sampled at grant
//   sd_blk_cnt[d]    number of blocks minus one, sampled at grant
//   sd_rd, sd_wr     per-drive level requests (read wins if both high)
//   sd_ack           one-hot acknowledge, high for the whole transfer
//   sd_buff_addr     byte index into the requester buffer
//   sd_buff_dout     read data to the requester
//   sd_buff_wr       one-cycle strobe: requester stores dout at addr
//   sd_buff_din[d]   requester buffer data, valid 1 cycle after sd_buff_addr
//   mem_addr/rd/wr   backing memory request, held until mem_ready
//   mem_wdata        backing memory write data
//   mem_rdata        backing memory read data, valid with mem_ready
//   mem_ready        one-cycle completion of the outstanding access
//   dbg_state        current FSM state, for observation only
//
// Handshakes
//   Drive request: the requester raises sd_rd/sd_wr and keeps it up until it
//   sees its sd_ack bit high, then drops it. sd_ack stays high until the last
//   byte has moved, then falls for at least one cycle before the next grant.
//   A request still high when the block server is idle again is a new request.
//   Memory: mem_rd or mem_wr (never both) is held with a stable mem_addr until
//   the cycle in which mem_ready is high; that cycle completes the access.
module sd_block_server #(
   parameter int         MEM_AW = 22,
   parameter logic [7:0] FILL   = 8'h00
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic [3:0][31:0]     sd_lba,
   input  logic [3:0][5:0]      sd_blk_cnt,
   input  logic [3:0]           sd_rd,
   input  logic [3:0]           sd_wr,
   output logic [3:0]           sd_ack,
   output logic [8:0]           sd_buff_addr,
   output logic [7:0]           sd_buff_dout,
   output logic                 sd_buff_wr,
   input  logic [3:0][7:0]      sd_buff_din,
   output logic [MEM_AW-1:0]    mem_addr,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [7:0]           mem_wdata,
   input  logic [7:0]           mem_rdata,
   input  logic                 mem_ready,
   output logic [3:0]           dbg_state
);

   localparam logic [3:0] IDLE      = 4'd0;
   localparam logic [3:0] SETUP     = 4'd1;
   localparam logic [3:0] RD_FETCH  = 4'd2;
   localparam logic [3:0] RD_WAIT   = 4'd3;
   localparam logic [3:0] RD_PUSH   = 4'd4;
   localparam logic [3:0] WR_ADDR   = 4'd5;
   localparam logic [3:0] WR_SAMPLE = 4'd6;
   localparam logic [3:0] WR_WAIT   = 4'd7;
   localparam logic [3:0] WR_NEXT   = 4'd8;
   localparam logic [3:0] DONE      = 4'd9;

   logic [3:0]  state;
   logic [1:0]  last_served;
   logic [1:0]  drv;
   logic [31:0] lba_q;
   logic [5:0]  blk_cnt_q;
   logic        dir_rd;
   logic [5:0]  kc;

   logic [3:0]  pending;
   logic        grant_valid;
   logic [1:0]  grant_drv;
   logic [32:0] blk_sum;
   logic        oor;
   logic        last_byte;
   logic        last_blk;
   logic [MEM_AW-1:0] map_addr;

   assign dbg_state = state;
   assign pending   = sd_rd | sd_wr;

   // Round-robin search starting just after the last drive served; the last
   // served drive itself is checked last (offset 4 wraps to offset 0).
   always_comb begin
      logic [1:0] idx;
      grant_valid = 1'b0;
      grant_drv   = 2'd0;
      idx         = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = last_served + 2'(i);
         if (!grant_valid && pending[idx]) begin
            grant_valid = 1'b1;
            grant_drv   = idx;
         end
      end
   end

   // 33-bit block number: a huge lba cannot wrap back into the window.
   assign blk_sum   = {1'b0, lba_q} + 33'(kc);
   assign oor       = |blk_sum[32:11];
   assign last_byte = &sd_buff_addr;
   assign last_blk  = (kc == blk_cnt_q);
   assign map_addr  = MEM_AW'({drv, blk_sum[10:0], sd_buff_addr});

   // sd_buff_addr doubles as the byte counter within the current block.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         sd_ack       <= '0;
         sd_buff_addr <= '0;
         sd_buff_dout <= '0;
         sd_buff_wr   <= 1'b0;
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         last_served  <= 2'd0;
         drv          <= 2'd0;
         lba_q        <= '0;
         blk_cnt_q    <= '0;
         dir_rd       <= 1'b0;
         kc           <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  drv       <= grant_drv;
                  lba_q     <= sd_lba[grant_drv];
                  blk_cnt_q <= sd_blk_cnt[grant_drv];
                  dir_rd    <= sd_rd[grant_drv];
                  sd_ack    <= 4'b0001 << grant_drv;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               sd_buff_addr <= '0;
               kc           <= '0;
               state        <= dir_rd ? RD_FETCH : WR_ADDR;
            end
            RD_FETCH: begin
               if (oor) begin
                  sd_buff_dout <= FILL;
                  sd_buff_wr   <= 1'b1;
                  state        <= RD_PUSH;
               end else begin
                  mem_rd   <= 1'b1;
                  mem_addr <= map_addr;
                  state    <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (mem_ready) begin
                  sd_buff_dout <= mem_rdata;
                  sd_buff_wr   <= 1'b1;
                  mem_rd       <= 1'b0;
                  state        <= RD_PUSH;
               end
            end
            RD_PUSH: begin
               sd_buff_wr   <= 1'b0;
               sd_buff_addr <= sd_buff_addr + 9'd1;
               state        <= RD_FETCH;
               if (last_byte) begin
                  kc <= kc + 6'd1;
                  if (last_blk) begin
                     sd_ack      <= '0;
                     last_served <= drv;
                     state       <= DONE;
                  end
               end
            end
            // The buffer read port is registered: the address presented in
            // WR_ADDR yields its data during WR_SAMPLE.
            WR_ADDR: begin
               state <= WR_SAMPLE;
            end
            WR_SAMPLE: begin
               mem_wdata <= sd_buff_din[drv];
               if (oor) begin
                  state <= WR_NEXT;
               end else begin
                  mem_wr   <= 1'b1;
                  mem_addr <= map_addr;
                  state    <= WR_WAIT;
               end
            end
            WR_WAIT: begin
               if (mem_ready) begin
                  mem_wr <= 1'b0;
                  state  <= WR_NEXT;
               end
            end
            WR_NEXT: begin
               sd_buff_addr <= sd_buff_addr + 9'd1;
               state        <= WR_ADDR;
               if (last_byte) begin
                  kc <= kc + 6'd1;
                  if (last_blk) begin
                     sd_ack      <= '0;
                     last_served <= drv;
                     state       <= DONE;
                  end
               end
            end
            // One cycle with ack low so the requester can tell transfers apart.
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_block_server.sv
// tb_sd_block_server
//   Self-checking bench for sd_block_server. A requester model (per-drive
//   sector buffers with a registered read port, request drop on ack) and a
//   backing memory model with programmable mem_ready delay surround the DUT.
//   Expected buffer strobes, memory writes, service order and read counts are
//   planned from the transfer rules before each batch of requests is issued.
module tb_sd_block_server;

   localparam logic [7:0] FILL   = 8'h00;
   localparam int         BUDGET = 30000;

   logic              CLK;
   logic              RESET_N;
   logic [3:0][31:0]  sd_lba;
   logic [3:0][5:0]   sd_blk_cnt;
   logic [3:0]        sd_rd;
   logic [3:0]        sd_wr;
   logic [3:0]        sd_ack;
   logic [8:0]        sd_buff_addr;
   logic [7:0]        sd_buff_dout;
   logic              sd_buff_wr;
   logic [3:0][7:0]   sd_buff_din;
   logic [21:0]       mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              mem_ready;
   logic [3:0]        dbg_state;

   sd_block_server #(.MEM_AW(22), .FILL(FILL)) dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .sd_lba       (sd_lba),
      .sd_blk_cnt   (sd_blk_cnt),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack),
      .sd_buff_addr (sd_buff_addr),
      .sd_buff_dout (sd_buff_dout),
      .sd_buff_wr   (sd_buff_wr),
      .sd_buff_din  (sd_buff_din),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   int cyc = 0;
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end
   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];      // {buff_addr, dout} per expected strobe
   logic [29:0] mw_q[$];       // {mem_addr, data} per expected memory write
   int          served_q[$];
   int          first_grant;
   int          rd_count = 0;
   int          strobe_cnt = 0;
   int          last_model = 0;
   int          mem_delay = 0;

   logic [7:0]  bufm[4][512];
   logic [8:0]  buf_addr_q = '0;
   logic [7:0]  mem_rt[int];   // memory contents seen by the DUT
   logic [7:0]  mem_md[int];   // memory contents predicted by the plan
   logic [3:0]  prev_ack = '0;
   int          wcnt = 0;
   logic [21:0] held_addr = '0;
   logic [1:0]  held_req = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] pat(input logic [21:0] a);
      return a[7:0] ^ a[16:9] ^ {6'b0, a[21:20]};
   endfunction

   function automatic logic [7:0] rt_get(input logic [21:0] a);
      return mem_rt.exists(int'(a)) ? mem_rt[int'(a)] : pat(a);
   endfunction

   function automatic logic [7:0] md_get(input logic [21:0] a);
      return mem_md.exists(int'(a)) ? mem_md[int'(a)] : pat(a);
   endfunction

   // Queue the expected traffic of one whole transfer; returns memory reads.
   function automatic int plan_xfer(input int d, input logic is_rd);
      int          reads = 0;
      logic [32:0] blk_no;
      logic [21:0] a;
      logic [7:0]  v;
      for (int k = 0; k <= int'(sd_blk_cnt[d]); k++) begin
         blk_no = {1'b0, sd_lba[d]} + 33'(k);
         for (int b = 0; b < 512; b++) begin
            a = {2'(d), blk_no[10:0], 9'(b)};
            if (is_rd) begin
               if (blk_no < 33'd2048) begin
                  v = md_get(a);
                  reads++;
               end else begin
                  v = FILL;
               end
               exp_q.push_back({9'(b), v});
            end else if (blk_no < 33'd2048) begin
               mw_q.push_back({a, bufm[d][b]});
               mem_md[int'(a)] = bufm[d][b];
            end
         end
      end
      return reads;
   endfunction

   // ---------------- requester, memory model and monitors ----------------
   initial begin
      sd_buff_din = '0;
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      forever begin
         @(negedge CLK);
         // registered buffer read port: data follows the previous address
         for (int d = 0; d < 4; d++) sd_buff_din[d] = bufm[d][buf_addr_q];
         buf_addr_q = sd_buff_addr;

         check("ack_onehot", 32'($countones(sd_ack) <= 1), 32'd1);
         check("mem_excl", 32'(mem_rd & mem_wr), 32'd0);
         check("mem_in_xfer", 32'((mem_rd | mem_wr) && (sd_ack == 4'd0)), 32'd0);

         if (sd_ack != 4'd0 && prev_ack == 4'd0) begin
            for (int d = 0; d < 4; d++) if (sd_ack[d]) served_q.push_back(d);
            if (first_grant < 0) first_grant = cyc;
         end
         prev_ack = sd_ack;
         for (int d = 0; d < 4; d++) begin
            if (sd_ack[d]) begin
               sd_rd[d] = 1'b0;
               sd_wr[d] = 1'b0;
            end
         end

         if (sd_buff_wr) begin
            strobe_cnt++;
            check("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("strobe", 32'({sd_buff_addr, sd_buff_dout}), 32'(exp_q.pop_front()));
         end

         if (!RESET_N) begin
            mem_ready = 1'b0;
            wcnt      = 0;
         end else begin
            if (wcnt > 0) begin
               check("mem_hold_req", 32'({mem_rd, mem_wr}), 32'(held_req));
               check("mem_hold_addr", 32'(mem_addr), 32'(held_addr));
            end
            if (mem_rd | mem_wr) begin
               if (wcnt == 0) begin
                  held_addr = mem_addr;
                  held_req  = {mem_rd, mem_wr};
               end
               if (wcnt == mem_delay) begin
                  mem_ready = 1'b1;
                  wcnt      = 0;
                  if (mem_rd) begin
                     mem_rdata = rt_get(mem_addr);
                     rd_count++;
                  end
                  if (mem_wr) begin
                     check("mem_wr_pending", 32'(mw_q.size() != 0), 32'd1);
                     if (mw_q.size() != 0) check("mem_wr", 32'({mem_addr, mem_wdata}), 32'(mw_q.pop_front()));
                     mem_rt[int'(mem_addr)] = mem_wdata;
                  end
               end else begin
                  mem_ready = 1'b0;
                  wcnt++;
               end
            end else begin
               mem_ready = 1'b0;
               wcnt      = 0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Plans the batch in round-robin order, raises the requests at the current
   // time and waits (bounded) until every drive has been served.
   task automatic run_batch(input logic [3:0] rdm, input logic [3:0] wrm);
      logic [3:0] pend;
      int order[$];
      int exp_reads;
      int rd0;
      int start;
      int n;
      pend = rdm | wrm;
      exp_reads = 0;
      while (pend != 4'd0) begin
         for (int k = 1; k <= 4; k++) begin
            int d;
            d = (last_model + k) % 4;
            if (pend[d]) begin
               order.push_back(d);
               pend[d] = 1'b0;
               last_model = d;
               break;
            end
         end
      end
      foreach (order[i]) exp_reads += plan_xfer(order[i], rdm[order[i]]);
      served_q.delete();
      first_grant = -1;
      rd0   = rd_count;
      start = cyc;
      sd_rd = rdm;
      sd_wr = wrm;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while ((sd_rd != 4'd0 || sd_wr != 4'd0 || sd_ack != 4'd0) && n < BUDGET);
      check("done_in_time", 32'(n < BUDGET), 32'd1);
      repeat (3) @(negedge CLK);
      check("grant_latency", 32'(first_grant - start), 32'd1);
      check("served_count", 32'(served_q.size()), 32'(order.size()));
      foreach (order[i]) if (i < served_q.size()) check("served_order", 32'(served_q[i]), 32'(order[i]));
      check("strobes_left", 32'(exp_q.size()), 32'd0);
      check("mem_wr_left", 32'(mw_q.size()), 32'd0);
      check("mem_rd_count", 32'(rd_count - rd0), 32'(exp_reads));
      exp_q.delete();
      mw_q.delete();
   endtask

   task automatic set_drive(input int d, input logic [31:0] lba, input logic [5:0] blk);
      sd_lba[d]     = lba;
      sd_blk_cnt[d] = blk;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int s0;
      logic [3:0] rdm;
      logic [3:0] wrm;
      RESET_N    = 1'b0;
      sd_rd      = '0;
      sd_wr      = '0;
      sd_lba     = '0;
      sd_blk_cnt = '0;
      for (int d = 0; d < 4; d++)
         for (int a = 0; a < 512; a++) bufm[d][a] = 8'($urandom_range(0, 255));

      repeat (3) @(negedge CLK);
      check("reset_ack", 32'(sd_ack), 32'd0);
      check("reset_buff", 32'({sd_buff_wr, sd_buff_addr, sd_buff_dout}), 32'd0);
      check("reset_mem", {mem_rd, mem_wr, mem_addr, mem_wdata}, 32'd0);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);

      // plain read, drive 0, block 0 holds i[7:0]
      set_drive(0, 32'd0, 6'd0);
      run_batch(4'b0001, 4'b0000);

      // round robin after drive 0: expect 1, 3, 0
      set_drive(1, 32'd7, 6'd0);
      set_drive(3, 32'd100, 6'd0);
      set_drive(0, 32'd1, 6'd0);
      run_batch(4'b1011, 4'b0000);

      // write, drive 2, lba 5, buffer holds 0xA5 ^ addr
      for (int a = 0; a < 512; a++) bufm[2][a] = 8'hA5 ^ 8'(a);
      set_drive(2, 32'd5, 6'd0);
      run_batch(4'b0000, 4'b0100);

      // outside the drive window
      set_drive(1, 32'd2048, 6'd0);
      run_batch(4'b0010, 4'b0000);
      set_drive(1, 32'd3000, 6'd0);
      run_batch(4'b0000, 4'b0010);

      // two blocks straddling the window end with a slow memory
      mem_delay = 3;
      set_drive(3, 32'd2047, 6'd1);
      run_batch(4'b1000, 4'b0000);
      mem_delay = 0;

      // reset in the middle of a read, then a fresh transfer from addr 0
      set_drive(0, 32'd0, 6'd0);
      void'(plan_xfer(0, 1'b1));
      s0 = strobe_cnt;
      sd_rd[0] = 1'b1;
      n = 0;
      while ((strobe_cnt - s0) < 100 && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      check("reset_mid_reached", 32'(n < 5000), 32'd1);
      #2 RESET_N = 1'b0;
      #1;
      check("abort_ack", 32'(sd_ack), 32'd0);
      check("abort_buff", 32'({sd_buff_wr, sd_buff_addr, sd_buff_dout}), 32'd0);
      check("abort_mem", {mem_rd, mem_wr, mem_addr, mem_wdata}, 32'd0);
      exp_q.delete();
      mw_q.delete();
      last_model = 0;
      sd_rd[0] = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      run_batch(4'b0001, 4'b0000);

      // randomized mixed batches
      for (int it = 0; it < 2; it++) begin
         rdm = 4'($urandom_range(0, 15));
         wrm = 4'($urandom_range(0, 15));
         if ((rdm | wrm) == 4'd0) rdm = 4'b0001;
         mem_delay = $urandom_range(0, 1);
         for (int d = 0; d < 4; d++) begin
            case ($urandom_range(0, 3))
               0:       sd_lba[d] = 32'($urandom_range(0, 2047));
               1:       sd_lba[d] = 32'($urandom_range(2045, 2047));
               2:       sd_lba[d] = 32'($urandom_range(2048, 65535));
               default: sd_lba[d] = $urandom();
            endcase
            sd_blk_cnt[d] = 6'($urandom_range(0, 1));
            for (int a = 0; a < 512; a++) bufm[d][a] = 8'($urandom_range(0, 255));
         end
         run_batch(rdm, wrm);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
